// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two requesters share one bit-serial adder.
// A round-robin arbiter picks a requester in IDLE, the operands are added
// LSB-first over W SHIFT cycles, and the result is held in DONE until the
// consumer takes it.
module serial_add_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_carry,
    output logic         rsp_id,
    input  logic         rsp_ready,
    output logic         busy
);

    // Counter only needs to reach W-1; keep at least one bit for W=1.
    localparam int CW = (W < 2) ? 1 : $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;

    logic          grant0;
    logic          grant1;
    logic          sum_bit;
    logic          carry_next;

    // Full adder majority: carry out is set when at least two inputs are set.
    function automatic logic majority3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end else begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    // Ready is offered only in IDLE and never while reset is asserted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset && (state_q == ST_IDLE)) begin
            req0_ready = grant0;
            req1_ready = grant1;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Next-state logic for the FSM and the serial datapath.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        last_d     = last_q;
        valid_d    = valid_q;
        sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = majority3(a_q[0], b_q[0], carry_q);
        case (state_q)
            ST_IDLE: begin
                if (req0_ready || req1_ready) begin
                    a_d     = req1_ready ? req1_a : req0_a;
                    b_d     = req1_ready ? req1_b : req0_b;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                sum_d        = sum_q >> 1;
                sum_d[W-1]   = sum_bit;
                carry_d      = carry_next;
                cnt_d        = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; req0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester n has an addition pending.
REQ-005 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W bits each: unsigned operands of requester n.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: requester n's operands are accepted on this edge.
REQ-007 The block SHALL have ports rsp_valid (output, 1), rsp_sum (output, W), rsp_carry (output, 1), rsp_id (output, 1): the result held for the consumer.
REQ-008 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-010 The block SHALL contain one shared bit-serial adder: 1-bit full adder, carry flop, and two W-bit operand shift registers plus one W-bit sum shift register.
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; no other reachable states.
REQ-012 In IDLE, reqN_ready SHALL be driven combinationally high only for the granted requester and low for the other; both SHALL be low in SHIFT and DONE.
REQ-013 Grant when only one reqN_valid is high: that requester. Grant when both are high: the requester not granted last (round-robin). Grant when neither is high: none.
REQ-014 On an accept edge (IDLE, reqN_valid and reqN_ready): the block SHALL load a, b and clear carry, bit counter and sum register, set rsp_id to N, update the last-grant pointer to N, and go to SHIFT.
REQ-015 Each SHIFT cycle, LSB-first: sum_bit = a[0]^b[0]^c, and c <= majority(a[0], b[0], c).
  - a and b shift right.
  - sum_bit enters the sum register at bit W-1 (shift right).
  - counter increments.
REQ-016 After exactly W SHIFT cycles the block SHALL enter DONE. rsp_valid rises W cycles after the accept edge. rsp_sum = (a+b) mod 2^W; rsp_carry = bit W of a+b.
REQ-017 In DONE, rsp_valid, rsp_sum, rsp_carry and rsp_id SHALL be held stable until rsp_ready is sampled high; on that edge the block goes to IDLE and rsp_valid falls.
REQ-018 The next request SHALL NOT be accepted on the response edge; it is accepted in IDLE on the following cycle at the earliest. Per-op occupancy is W+2 cycles minimum.
REQ-019 Operand or valid changes on the request ports during SHIFT/DONE SHALL have no effect. A requester SHALL hold valid and operands stable until its ready.
REQ-020 rsp_ready high outside DONE SHALL be ignored.
REQ-021 W=1 SHALL work: one SHIFT cycle, rsp_sum = a^b, rsp_carry = a&b.

Reset
REQ-022 While reset is sampled high, the block SHALL go to IDLE on the next edge from any state, aborting any in-flight operation with no response produced.
REQ-023 Reset values SHALL be: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0, carry=0, counter=0, last-grant pointer=1 (req0 wins the first contention).
REQ-024 req0_ready and req1_ready SHALL be forced low during any cycle in which reset is high.

Verification
REQ-025 Single op: req0 a=4'b1111, b=4'b0001, rsp_ready=1 -> rsp_valid exactly 4 cycles after the accept edge, rsp_sum=4'b0000, rsp_carry=1, rsp_id=0.
REQ-026 Contention after reset: req0 (3+4) and req1 (9+9) valid together -> req0 first (sum 4'b0111, carry 0, id 0), then req1 (sum 4'b0010, carry 1, id 1).
REQ-027 Fairness: both valid continuously for 6 ops -> grant order 0,1,0,1,0,1; each grant starts 6 cycles after the previous one.
REQ-028 Backpressure: rsp_ready held low 5 cycles in DONE -> rsp_* stable, busy=1, both readys low; accept occurs 1 cycle after rsp_ready handshake.
REQ-029 Reset mid-op: reset pulsed after 2 SHIFT cycles of 4'b1111+4'b1111 -> next cycle IDLE, rsp_valid=0. Then 4'b0000+4'b0000 -> rsp_sum=0, rsp_carry=0 (no stale carry).
REQ-030 Extremes: 4'b1111+4'b1111 -> rsp_sum=4'b1110, rsp_carry=1. Rerun with W=1: 1+1 -> rsp_sum=0, rsp_carry=1, rsp_valid 1 cycle after accept.
